// File: rtl/regfile_sb.sv
// Integer register file with two combinational read ports, one write port,
// optional write-to-read bypass, hardwired zero register and busy-bit scoreboard.

module regfile_sb_entry #(
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] RST_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic            i_set,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_d,
  output logic [XLEN-1:0] o_q,
  output logic            o_busy
);
  logic [XLEN-1:0] r_q;
  logic            r_busy;

  // Busy priority: flush clears, a new producer sets, a retiring write clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= RST_VAL;
      r_busy <= 1'b0;
    end else begin
      if (i_we) r_q <= i_d;
      if (i_flush)    r_busy <= 1'b0;
      else if (i_set) r_busy <= 1'b1;
      else if (i_we)  r_busy <= 1'b0;
    end
  end

  assign o_q    = r_q;
  assign o_busy = r_busy;
endmodule

module regfile_sb #(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int AW         = 5,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1,
  parameter int INIT_INDEX = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWEn,
  input  logic [AW-1:0]    AddrD,
  input  logic [XLEN-1:0]  DataD,
  input  logic [AW-1:0]    AddrA,
  input  logic [AW-1:0]    AddrB,
  output logic [XLEN-1:0]  DataA,
  output logic [XLEN-1:0]  DataB,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_rd,
  input  logic             flush,
  output logic             busy_a,
  output logic             busy_b,
  output logic [NREGS-1:0] busy_vec
);
  localparam logic [AW:0] NR = (AW+1)'(NREGS);

  logic                        w_wvalid, w_ivalid;
  logic [NREGS-1:0]            w_we, w_set, w_busy;
  logic [NREGS-1:0][XLEN-1:0]  w_q;
  logic [XLEN-1:0]             w_qa, w_qb;
  logic                        w_ba, w_bb, w_va, w_vb, w_hit_a, w_hit_b;

  assign w_wvalid = RegWEn && ({1'b0, AddrD} < NR) &&
                    !((ZERO_REG != 0) && (AddrD == '0));
  assign w_ivalid = issue_en && ({1'b0, issue_rd} < NR) &&
                    !((ZERO_REG != 0) && (issue_rd == '0));

  // Register 0 under ZERO_REG never sees a write or set, so it holds its 0 reset value.
  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    localparam logic [XLEN-1:0] RV = (INIT_INDEX != 0) ? XLEN'(g) : '0;
    assign w_we[g]  = w_wvalid && (AddrD == AW'(g));
    assign w_set[g] = w_ivalid && (issue_rd == AW'(g));
    regfile_sb_entry #(.XLEN(XLEN), .RST_VAL(RV)) u_ent (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we[g]),
      .i_set   (w_set[g]),
      .i_flush (flush),
      .i_d     (DataD),
      .o_q     (w_q[g]),
      .o_busy  (w_busy[g])
    );
  end

  always_comb begin
    w_qa = '0;
    w_qb = '0;
    w_ba = 1'b0;
    w_bb = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (AddrA == AW'(i)) begin
        w_qa = w_q[i];
        w_ba = w_busy[i];
      end
      if (AddrB == AW'(i)) begin
        w_qb = w_q[i];
        w_bb = w_busy[i];
      end
    end
  end

  assign w_va    = ({1'b0, AddrA} < NR) && !((ZERO_REG != 0) && (AddrA == '0));
  assign w_vb    = ({1'b0, AddrB} < NR) && !((ZERO_REG != 0) && (AddrB == '0));
  assign w_hit_a = (BYPASS != 0) && w_wvalid && (AddrD == AddrA);
  assign w_hit_b = (BYPASS != 0) && w_wvalid && (AddrD == AddrB);

  assign DataA    = !w_va ? '0 : (w_hit_a ? DataD : w_qa);
  assign DataB    = !w_vb ? '0 : (w_hit_b ? DataD : w_qb);
  assign busy_a   = w_va && !w_hit_a && w_ba;
  assign busy_b   = w_vb && !w_hit_b && w_bb;
  assign busy_vec = w_busy;
endmodule

// File: tb/tb_regfile_sb.sv
// Random + directed bench for regfile_sb: two instances (32 regs with bypass,
// 24 regs without) share stimulus and are checked against an array model.

module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic        RegWEn, issue_en, flush;
  logic [4:0]  AddrD, AddrA, AddrB, issue_rd;
  logic [31:0] DataD;

  logic [31:0] da0, db0, da1, db1;
  logic        ba0, bb0, ba1, bb1;
  logic [31:0] bv0;
  logic [23:0] bv1;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  logic [31:0] mregs [2][32];
  bit          mbusy [2][32];

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(1), .ZERO_REG(1), .INIT_INDEX(1)) dut0 (
    .clk(clk), .rst(rst), .RegWEn(RegWEn), .AddrD(AddrD), .DataD(DataD),
    .AddrA(AddrA), .AddrB(AddrB), .DataA(da0), .DataB(db0),
    .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush),
    .busy_a(ba0), .busy_b(bb0), .busy_vec(bv0));

  regfile_sb #(.XLEN(32), .NREGS(24), .AW(5), .BYPASS(0), .ZERO_REG(1), .INIT_INDEX(1)) dut1 (
    .clk(clk), .rst(rst), .RegWEn(RegWEn), .AddrD(AddrD), .DataD(DataD),
    .AddrA(AddrA), .AddrB(AddrB), .DataA(da1), .DataB(db1),
    .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush),
    .busy_a(ba1), .busy_b(bb1), .busy_vec(bv1));

  function automatic int nregs(int k);
    return (k == 0) ? 32 : 24;
  endfunction

  function automatic bit wvalid(int k);
    return RegWEn && (int'(AddrD) < nregs(k)) && (AddrD != 0);
  endfunction

  function automatic bit ivalid(int k);
    return issue_en && (int'(issue_rd) < nregs(k)) && (issue_rd != 0);
  endfunction

  function automatic logic [31:0] exp_data(int k, logic [4:0] a);
    if (int'(a) >= nregs(k) || a == 0) return 32'h0;
    if (k == 0 && wvalid(k) && AddrD == a) return DataD;
    return mregs[k][a];
  endfunction

  function automatic bit exp_busy(int k, logic [4:0] a);
    if (int'(a) >= nregs(k) || a == 0) return 1'b0;
    if (k == 0 && wvalid(k) && AddrD == a) return 1'b0;
    return mbusy[k][a];
  endfunction

  function automatic logic [31:0] exp_vec(int k);
    logic [31:0] v = '0;
    for (int i = 0; i < nregs(k); i++) v[i] = mbusy[k][i];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) begin
        mregs[k][i] = 32'(i);
        mbusy[k][i] = 1'b0;
      end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (wvalid(k)) mregs[k][AddrD] = DataD;
        if (flush) begin
          for (int i = 0; i < 32; i++) mbusy[k][i] = 1'b0;
        end else begin
          if (wvalid(k)) mbusy[k][AddrD] = 1'b0;
          if (ivalid(k)) mbusy[k][issue_rd] = 1'b1;
        end
      end
    end
  end

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
    end
  endtask

  task automatic check_all();
    chk("d0.DataA", da0, exp_data(0, AddrA));
    chk("d0.DataB", db0, exp_data(0, AddrB));
    chk("d0.busy_a", ba0, exp_busy(0, AddrA));
    chk("d0.busy_b", bb0, exp_busy(0, AddrB));
    chk("d0.busy_vec", bv0, exp_vec(0));
    chk("d1.DataA", da1, exp_data(1, AddrA));
    chk("d1.DataB", db1, exp_data(1, AddrB));
    chk("d1.busy_a", ba1, exp_busy(1, AddrA));
    chk("d1.busy_b", bb1, exp_busy(1, AddrB));
    chk("d1.busy_vec", bv1, exp_vec(1));
  endtask

  always @(negedge clk) if (chk_en) check_all();

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWEn = 0; issue_en = 0; flush = 0;
  endtask

  initial begin
    rst = 1; idle();
    AddrD = 0; DataD = 0; AddrA = 7; AddrB = 0; issue_rd = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 0;
    step();
    chk_en = 1;

    // reset contents
    chk("rst.d0.A7", da0, 32'h7);
    chk("rst.d0.B0", db0, 32'h0);
    chk("rst.d0.vec", bv0, 32'h0);
    chk("rst.d1.A7", da1, 32'h7);

    // write 5 with same-cycle read
    RegWEn = 1; AddrD = 5; DataD = 32'hDEADBEEF; AddrA = 5; #1;
    chk("byp1.pre", da0, 32'hDEADBEEF);
    chk("byp0.pre", da1, 32'h5);
    step(); idle(); #1;
    chk("byp1.post", da0, 32'hDEADBEEF);
    chk("byp0.post", da1, 32'hDEADBEEF);

    // zero register ignores write and issue
    RegWEn = 1; AddrD = 0; DataD = 32'h12345678; issue_en = 1; issue_rd = 0; AddrA = 0; #1;
    chk("zero.pre", da0, 32'h0);
    step(); idle(); #1;
    chk("zero.post", da0, 32'h0);
    chk("zero.vec0", bv0[0], 1'b0);

    // scoreboard life cycle on 9
    issue_en = 1; issue_rd = 9;
    step(); idle(); AddrA = 9; #1;
    chk("sb.vec9", bv0[9], 1'b1);
    chk("sb.busy_a", ba0, 1'b1);
    RegWEn = 1; AddrD = 9; DataD = 32'hCAFE0009; #1;
    chk("sb.wb.byp1", ba0, 1'b0);
    chk("sb.wb.byp0", ba1, 1'b1);
    step(); idle(); #1;
    chk("sb.vec9.clr", bv0[9], 1'b0);

    // issue and write same register: set wins
    issue_en = 1; issue_rd = 3; RegWEn = 1; AddrD = 3; DataD = 32'h33;
    step(); idle(); #1;
    chk("sim.vec3.d0", bv0[3], 1'b1);
    chk("sim.vec3.d1", bv1[3], 1'b1);

    // flush drops a concurrent issue
    flush = 1; issue_en = 1; issue_rd = 4;
    step(); idle(); #1;
    chk("flush.vec", bv0, 32'h0);

    // address beyond NREGS on the 24-entry instance
    issue_en = 1; issue_rd = 28; RegWEn = 1; AddrD = 28; DataD = 32'hBAD;
    step(); idle(); AddrA = 28; #1;
    chk("oob.d1.data", da1, 32'h0);
    chk("oob.d1.vec", bv1, 24'h0);
    chk("oob.d0.data", da0, 32'hBAD);

    // async reset between edges
    issue_en = 1; issue_rd = 7;
    step(); idle(); AddrA = 5;
    @(negedge clk); #1;
    rst = 1; model_reset(); #1;
    chk("arst.vec", bv0, 32'h0);
    chk("arst.reg5", da0, 32'h5);
    check_all();
    #1 rst = 0;

    for (int n = 0; n < 3000; n++) begin
      step();
      RegWEn   = ($urandom_range(0, 1) == 1);
      issue_en = ($urandom_range(0, 9) < 4);
      flush    = ($urandom_range(0, 19) == 0);
      AddrD    = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      issue_rd = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      AddrA    = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      AddrB    = ($urandom_range(0, 3) == 0) ? AddrA : 5'($urandom_range(0, 31));
      DataD    = $urandom;
      if ($urandom_range(0, 99) == 0) begin
        #6 rst = 1; model_reset(); #1;
        check_all();
        rst = 0;
      end
    end

    step();
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
